rram_macro_emu: RTL and testbench

- Synthesizable, cycle-based responder model of the RRAM macro pin interface, sitting on the macro side of the write/read FSM.
- Accepts the FSM's aclk-strobed write pulses and sense-amp reads.
- Stores a per-cell conductance code and returns sa_do/sa_rdy with programmable latency.
- Used for FPGA prototyping and as a synthesizable stand-in for the analog macro in regression.

---
 rtl/rram_macro_emu.sv | 171 +++++++++++++++++
 tb/tb_rram_macro_emu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_macro_emu.sv
// RRAM macro emulator: per-cell conductance store behind the analog pin interface.
// Latency: writes land on the strobe edge; sa_rdy pulses SA_LAT cycles after the read strobe cycle.
// Backpressure: none; strobes arriving while a read is in flight are dropped and flagged in proto_err.
//
// Ports:
//   mclk, rst                  clock, synchronous active-high reset
//   aclk                       analog strobe; a rising edge (sampled on mclk) starts an operation
//   bl_en, sl_en, wl_en        bitline (SET) / sourceline (RESET) / wordline enables
//   we, set_rst, di            write select, SET/RESET select, per-cell write mask
//   rram_addr, read_ref, sa_en word address (low DEPTH_W bits used), sense threshold, sense enable
//   sa_do, sa_rdy, busy        sensed word, one-cycle read-done pulse, read in flight
//   proto_err                  sticky protocol error, cleared only by rst
//   dbg_addr, dbg_bit, dbg_g   combinational peek at a single cell's conductance code
module rram_macro_emu #(
  parameter int WORD_W   = 48,
  parameter int ADDR_W   = 16,
  parameter int DEPTH_W  = 4,
  parameter int G_W      = 6,
  parameter int INIT_G   = 32,
  parameter int SET_STEP = 4,
  parameter int RST_STEP = 4,
  parameter int SA_LAT   = 3
) (
  input  logic                      mclk,
  input  logic                      rst,
  input  logic                      aclk,
  input  logic                      bl_en,
  input  logic                      sl_en,
  input  logic                      wl_en,
  input  logic                      we,
  input  logic                      set_rst,
  input  logic [WORD_W-1:0]         di,
  input  logic [ADDR_W-1:0]         rram_addr,
  input  logic [G_W-1:0]            read_ref,
  input  logic                      sa_en,
  output logic [WORD_W-1:0]         sa_do,
  output logic                      sa_rdy,
  output logic                      busy,
  output logic                      proto_err,
  input  logic [DEPTH_W-1:0]        dbg_addr,
  input  logic [$clog2(WORD_W)-1:0] dbg_bit,
  output logic [G_W-1:0]            dbg_g
);

  localparam int           WORDS    = 1 << DEPTH_W;
  localparam logic [G_W:0] G_MAX    = (G_W+1)'((1 << G_W) - 1);
  localparam logic [3:0]   LAT_LOAD = 4'(SA_LAT - 1);

  typedef enum logic {IDLE, READ_WAIT} state_t;
  state_t state, state_nxt;

  logic [G_W-1:0]     cells [WORDS][WORD_W];
  logic               aclk_q;
  logic               strb;
  logic [3:0]         cnt;
  logic [DEPTH_W-1:0] rd_addr;
  logic [DEPTH_W-1:0] wr_addr;
  logic [DEPTH_W-1:0] cmp_addr;
  logic [G_W-1:0]     rd_ref;
  logic [G_W-1:0]     cmp_ref;
  logic [WORD_W-1:0]  cmp_vec;
  logic               pulse_ok;
  logic               do_write;
  logic               do_read;
  logic               err_evt;
  logic               done_evt;
  logic               unused_addr_hi;

  assign strb           = aclk & ~aclk_q;
  assign wr_addr        = rram_addr[DEPTH_W-1:0];
  assign unused_addr_hi = ^rram_addr[ADDR_W-1:DEPTH_W];
  assign pulse_ok       = wl_en & (set_rst ? bl_en : sl_en);
  // The rdy cycle still belongs to READ_WAIT (cnt == 0) but is no longer busy.
  assign busy           = (state == READ_WAIT) && (cnt != 4'd0);

  // Saturating steps, computed one bit wider so overflow/borrow is visible.
  function automatic logic [G_W-1:0] g_set(input logic [G_W-1:0] g);
    logic [G_W:0] sum;
    sum = {1'b0, g} + (G_W+1)'(SET_STEP);
    return (sum > G_MAX) ? G_MAX[G_W-1:0] : sum[G_W-1:0];
  endfunction

  function automatic logic [G_W-1:0] g_rst(input logic [G_W-1:0] g);
    logic [G_W:0] diff;
    diff = {1'b0, g} - (G_W+1)'(RST_STEP);
    return diff[G_W] ? '0 : diff[G_W-1:0];
  endfunction

  always_ff @(posedge mclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // done_evt fires on the edge that makes sa_rdy visible: the edge where the
  // counter reaches 0, or the strobe edge itself when SA_LAT is 1.
  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    do_read   = 1'b0;
    err_evt   = 1'b0;
    done_evt  = 1'b0;
    cmp_addr  = rd_addr;
    cmp_ref   = rd_ref;
    case (state)
      IDLE: begin
        cmp_addr = wr_addr;
        cmp_ref  = read_ref;
        if (strb) begin
          if (we) begin
            do_write = pulse_ok;
            err_evt  = ~pulse_ok | sa_en;
          end else if (sa_en & wl_en) begin
            do_read   = 1'b1;
            done_evt  = (SA_LAT == 1);
            state_nxt = READ_WAIT;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      READ_WAIT: begin
        err_evt  = strb;
        done_evt = (cnt == 4'd1);
        if (cnt == 4'd0) state_nxt = IDLE;
      end
    endcase
  end

  // Cells cannot change while a read is in flight, so sensing one edge early
  // samples the same contents the completion cycle would.
  always_comb begin
    cmp_vec = '0;
    for (int i = 0; i < WORD_W; i++) cmp_vec[i] = (cells[cmp_addr][i] >= cmp_ref);
  end

  always_comb begin
    dbg_g = '0;
    if (int'(dbg_bit) < WORD_W) dbg_g = cells[dbg_addr][dbg_bit];
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      aclk_q    <= 1'b0;
      cnt       <= 4'd0;
      rd_addr   <= '0;
      rd_ref    <= '0;
      sa_do     <= '0;
      sa_rdy    <= 1'b0;
      proto_err <= 1'b0;
      for (int w = 0; w < WORDS; w++)
        for (int i = 0; i < WORD_W; i++) cells[w][i] <= G_W'(INIT_G);
    end else begin
      aclk_q <= aclk;
      sa_rdy <= done_evt;
      if (err_evt)  proto_err <= 1'b1;
      if (done_evt) sa_do     <= cmp_vec;
      if (do_read) begin
        rd_addr <= wr_addr;
        rd_ref  <= read_ref;
        cnt     <= LAT_LOAD;
      end else if (state == READ_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_write) begin
        for (int i = 0; i < WORD_W; i++)
          if (di[i]) cells[wr_addr][i] <= set_rst ? g_set(cells[wr_addr][i]) : g_rst(cells[wr_addr][i]);
      end
    end
  end

endmodule

// File: tb/tb_rram_macro_emu.sv
module tb_rram_macro_emu;
  localparam int WORD_W = 48;
  localparam int ADDR_W = 16;
  localparam int DEPTH_W = 4;
  localparam int G_W = 6;

  logic mclk = 1'b0;
  logic rst, aclk, bl_en, sl_en, wl_en, we, set_rst, sa_en;
  logic [WORD_W-1:0] di;
  logic [ADDR_W-1:0] rram_addr;
  logic [G_W-1:0]    read_ref;
  logic [WORD_W-1:0] sa_do;
  logic              sa_rdy, busy, proto_err;
  logic [DEPTH_W-1:0] dbg_addr;
  logic [5:0]        dbg_bit;
  logic [G_W-1:0]    dbg_g;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: integer conductance per cell, sticky error flag.
  int gm[16][48];
  bit err_m;

  always #5 mclk = ~mclk;

  rram_macro_emu dut (
    .mclk(mclk), .rst(rst), .aclk(aclk), .bl_en(bl_en), .sl_en(sl_en), .wl_en(wl_en),
    .we(we), .set_rst(set_rst), .di(di), .rram_addr(rram_addr), .read_ref(read_ref),
    .sa_en(sa_en), .sa_do(sa_do), .sa_rdy(sa_rdy), .busy(busy), .proto_err(proto_err),
    .dbg_addr(dbg_addr), .dbg_bit(dbg_bit), .dbg_g(dbg_g)
  );

  task automatic model_reset();
    for (int a = 0; a < 16; a++) for (int b = 0; b < 48; b++) gm[a][b] = 32;
    err_m = 1'b0;
  endtask

  // Strobe accepted while the macro is idle; returns whether a read was launched.
  task automatic model_pulse(input logic w, s, b, l, wl, sa, input logic [15:0] a,
                             input logic [47:0] d, output bit rd_ok);
    bit ok;
    int wa;
    wa = int'(a[3:0]);
    rd_ok = 1'b0;
    if (w) begin
      ok = wl && (s ? b : l);
      if (!ok || sa) err_m = 1'b1;
      if (ok) for (int i = 0; i < 48; i++) if (d[i]) begin
        if (s) gm[wa][i] = (gm[wa][i] + 4 > 63) ? 63 : gm[wa][i] + 4;
        else   gm[wa][i] = (gm[wa][i] - 4 < 0) ? 0 : gm[wa][i] - 4;
      end
    end else begin
      rd_ok = sa && wl;
      if (!rd_ok) err_m = 1'b1;
    end
  endtask

  function automatic logic [47:0] exp_do(input int a, input int r);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < 48; i++) v[i] = (gm[a][i] >= r);
    return v;
  endfunction

  task automatic idle_inputs();
    aclk = 0; bl_en = 0; sl_en = 0; wl_en = 0; we = 0; set_rst = 0; sa_en = 0;
    di = '0; rram_addr = '0; read_ref = '0; dbg_addr = '0; dbg_bit = '0;
  endtask

  task automatic do_reset();
    @(negedge mclk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    model_reset();
  endtask

  // One aclk-high cycle; returns at the negedge just after the strobe edge.
  task automatic strobe(input logic w, s, b, l, wl, sa, input logic [15:0] a,
                        input logic [47:0] d, input logic [5:0] r);
    @(negedge mclk);
    we = w; set_rst = s; bl_en = b; sl_en = l; wl_en = wl; sa_en = sa;
    rram_addr = a; di = d; read_ref = r; aclk = 1'b1;
    @(negedge mclk);
    aclk = 1'b0;
  endtask

  // Cycles counted from the strobe cycle; -1 if sa_rdy never came.
  task automatic wait_rdy(output int lat);
    lat = 1;
    while (!sa_rdy && lat < 20) begin
      @(negedge mclk);
      lat++;
    end
    if (!sa_rdy) lat = -1;
  endtask

  task automatic peek(input int a, input int b, output int g);
    dbg_addr = DEPTH_W'(a);
    dbg_bit = 6'(b);
    #1;
    g = int'(dbg_g);
  endtask

  task automatic test_reset();
    int g, bad;
    do_reset();
    n_checks++; if (sa_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_sa_rdy got=%b exp=0", sa_rdy); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    n_checks++; if (sa_do !== 48'h0) begin n_fail++; $display("FAIL reset_sa_do got=%h exp=0", sa_do); end
    bad = 0;
    for (int a = 0; a < 16; a++) for (int b = 0; b < 48; b++) begin
      peek(a, b, g);
      if (g != 32) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reset_cells got=%0d_bad_cells exp=0", bad); end
  endtask

  task automatic test_read_basic();
    bit rd_ok;
    int lat;
    logic [47:0] ones;
    ones = 48'hFFFF_FFFF_FFFF;
    strobe(0, 0, 0, 0, 1, 1, 16'd5, '0, 6'd32);
    model_pulse(0, 0, 0, 0, 1, 1, 16'd5, '0, rd_ok);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy_inflight got=%b exp=1", busy); end
    wait_rdy(lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL read_latency got=%0d exp=3", lat); end
    n_checks++; if (sa_do !== ones) begin n_fail++; $display("FAIL read_ref32 got=%h exp=%h", sa_do, ones); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_done got=%b exp=0", busy); end
    @(negedge mclk);
    n_checks++; if (sa_rdy !== 1'b0) begin n_fail++; $display("FAIL read_rdy_one_cycle got=%b exp=0", sa_rdy); end
    n_checks++; if (sa_do !== ones) begin n_fail++; $display("FAIL read_do_hold got=%h exp=%h", sa_do, ones); end
    strobe(0, 0, 0, 0, 1, 1, 16'd5, '0, 6'd33);
    wait_rdy(lat);
    n_checks++; if (lat != 3 || sa_do !== exp_do(5, 33)) begin
      n_fail++; $display("FAIL read_ref33 got=%h lat=%0d exp=%h lat=3", sa_do, lat, exp_do(5, 33)); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL read_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_set_reset_sat();
    bit rd_ok;
    int g;
    strobe(1, 1, 1, 0, 1, 0, 16'd2, 48'h1, '0);
    model_pulse(1, 1, 1, 0, 1, 0, 16'd2, 48'h1, rd_ok);
    peek(2, 0, g); n_checks++; if (g != 36) begin n_fail++; $display("FAIL set_once got=%0d exp=36", g); end
    peek(2, 1, g); n_checks++; if (g != 32) begin n_fail++; $display("FAIL set_neighbour_bit got=%0d exp=32", g); end
    peek(3, 0, g); n_checks++; if (g != 32) begin n_fail++; $display("FAIL set_neighbour_word got=%0d exp=32", g); end
    for (int k = 0; k < 8; k++) begin
      strobe(1, 1, 1, 0, 1, 0, 16'd2, 48'h1, '0);
      model_pulse(1, 1, 1, 0, 1, 0, 16'd2, 48'h1, rd_ok);
    end
    peek(2, 0, g); n_checks++; if (g != 63 || gm[2][0] != 63) begin n_fail++; $display("FAIL set_saturate got=%0d exp=63", g); end
    for (int k = 0; k < 17; k++) begin
      strobe(1, 0, 0, 1, 1, 0, 16'd2, 48'h1, '0);
      model_pulse(1, 0, 0, 1, 1, 0, 16'd2, 48'h1, rd_ok);
    end
    peek(2, 0, g); n_checks++; if (g != 0) begin n_fail++; $display("FAIL reset_saturate got=%0d exp=0", g); end
    // aclk held high over several edges must count as a single pulse
    @(negedge mclk);
    we = 1; set_rst = 1; bl_en = 1; sl_en = 0; wl_en = 1; sa_en = 0;
    rram_addr = 16'd7; di = 48'h1; aclk = 1'b1;
    repeat (4) @(negedge mclk);
    aclk = 1'b0;
    model_pulse(1, 1, 1, 0, 1, 0, 16'd7, 48'h1, rd_ok);
    peek(7, 0, g); n_checks++; if (g != gm[7][0]) begin n_fail++; $display("FAIL held_aclk got=%0d exp=%0d", g, gm[7][0]); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL set_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_alias();
    bit rd_ok;
    int g, lat;
    strobe(1, 1, 1, 0, 1, 0, 16'h0013, 48'h20, '0);
    model_pulse(1, 1, 1, 0, 1, 0, 16'h0013, 48'h20, rd_ok);
    peek(3, 5, g); n_checks++; if (g != 36) begin n_fail++; $display("FAIL alias_write got=%0d exp=36", g); end
    strobe(0, 0, 0, 0, 1, 1, 16'hFFF3, '0, 6'd36);
    wait_rdy(lat);
    n_checks++; if (lat != 3 || sa_do !== exp_do(3, 36)) begin
      n_fail++; $display("FAIL alias_read got=%h lat=%0d exp=%h lat=3", sa_do, lat, exp_do(3, 36)); end
  endtask

  task automatic test_back_to_back();
    int g, bad;
    logic [47:0] exp;
    exp = exp_do(5, 32);
    @(negedge mclk);
    we = 0; set_rst = 0; bl_en = 0; sl_en = 0; wl_en = 1; sa_en = 1;
    rram_addr = 16'd5; read_ref = 6'd32; aclk = 1'b1;
    @(negedge mclk);
    aclk = 1'b0;
    n_checks++; if (sa_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_c1 got=%b exp=0", sa_rdy); end
    @(negedge mclk);
    we = 1; set_rst = 1; bl_en = 1; wl_en = 1; sa_en = 0; di = 48'hFFFF_FFFF_FFFF; aclk = 1'b1;
    n_checks++; if (sa_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_c2 got=%b exp=0", sa_rdy); end
    @(negedge mclk);
    aclk = 1'b0;
    err_m = 1'b1;
    n_checks++; if (sa_rdy !== 1'b1 || sa_do !== exp) begin
      n_fail++; $display("FAIL b2b_rdy_c3 got=%b/%h exp=1/%h", sa_rdy, sa_do, exp); end
    n_checks++; if (proto_err !== err_m) begin n_fail++; $display("FAIL b2b_proto_err got=%b exp=%b", proto_err, err_m); end
    bad = 0;
    for (int b = 0; b < 48; b++) begin
      peek(5, b, g);
      if (g != gm[5][b]) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_write_ignored got=%0d_bad_cells exp=0", bad); end
  endtask

  task automatic test_proto_err();
    bit rd_ok;
    int g, lat;
    do_reset();
    strobe(1, 1, 0, 1, 1, 0, 16'd4, 48'hFFFF_FFFF_FFFF, '0);
    model_pulse(1, 1, 0, 1, 1, 0, 16'd4, 48'hFFFF_FFFF_FFFF, rd_ok);
    peek(4, 0, g); n_checks++; if (g != gm[4][0]) begin n_fail++; $display("FAIL perr_no_change got=%0d exp=%0d", g, gm[4][0]); end
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_set got=%b exp=1", proto_err); end
    strobe(0, 0, 0, 0, 1, 1, 16'd4, '0, 6'd10);
    wait_rdy(lat);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
    do_reset();
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_clear got=%b exp=0", proto_err); end
  endtask

  task automatic test_reset_mid_read();
    bit rd_ok, seen;
    int g, bad;
    strobe(1, 1, 1, 0, 1, 0, 16'd9, 48'hFF, '0);
    model_pulse(1, 1, 1, 0, 1, 0, 16'd9, 48'hFF, rd_ok);
    strobe(0, 0, 0, 0, 1, 1, 16'd9, '0, 6'd30);
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (sa_rdy) seen = 1'b1;
      @(negedge mclk);
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rdy got=%b exp=0", seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    bad = 0;
    for (int a = 0; a < 16; a++) for (int b = 0; b < 48; b++) begin
      peek(a, b, g);
      if (g != 32) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_cells got=%0d_bad_cells exp=0", bad); end
  endtask

  task automatic test_random();
    bit rd_ok, seen;
    logic w, s, b, l, wl, sa;
    logic [15:0] a;
    logic [47:0] d;
    logic [5:0] r;
    int g, lat, pa, pb;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) != 0);
      wl = ($urandom_range(0, 7) != 0);
      sa = w ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
      a = 16'($urandom);
      d = {16'($urandom), $urandom};
      r = 6'($urandom_range(20, 44));
      strobe(w, s, b, l, wl, sa, a, d, r);
      model_pulse(w, s, b, l, wl, sa, a, d, rd_ok);
      if (rd_ok) begin
        wait_rdy(lat);
        n_checks++; if (lat != 3 || sa_do !== exp_do(int'(a[3:0]), int'(r))) begin
          n_fail++; $display("FAIL rand_read[%0d] got=%h lat=%0d exp=%h lat=3", n, sa_do, lat, exp_do(int'(a[3:0]), int'(r))); end
      end else begin
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (sa_rdy) seen = 1'b1;
          @(negedge mclk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rand_spurious_rdy[%0d] got=1 exp=0", n); end
      end
      n_checks++; if (proto_err !== err_m) begin n_fail++; $display("FAIL rand_proto_err[%0d] got=%b exp=%b", n, proto_err, err_m); end
      for (int k = 0; k < 3; k++) begin
        pa = int'(a[3:0]);
        pb = $urandom_range(0, 47);
        peek(pa, pb, g);
        n_checks++; if (g != gm[pa][pb]) begin n_fail++; $display("FAIL rand_cell[%0d] a=%0d b=%0d got=%0d exp=%0d", n, pa, pb, g, gm[pa][pb]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_read_basic();
    test_set_reset_sat();
    test_alias();
    test_back_to_back();
    test_proto_err();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
